// File: rtl/mips_alu_pipe.sv
// In-order MIPS32-style integer execute pipeline: ID stage with operand forwarding,
// WB stage retiring into a 32-entry register bank, multi-cycle MUL interlock and HLT drain.
module mips_alu_pipe #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            halted,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_SLT  = 6'b000100;
  localparam logic [5:0] OP_MUL  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_NOR  = 6'b010010;
  localparam logic [5:0] OP_XOR  = 6'b010110;
  localparam logic [5:0] OP_SLL  = 6'b100101;
  localparam logic [5:0] OP_SRL  = 6'b100111;
  localparam logic [5:0] OP_SRA  = 6'b101001;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  localparam logic [3:0] MUL_INIT = 4'(MUL_STAGES);

  logic [XLEN-1:0] regs_q [32];

  logic            id_valid_q;
  logic [31:0]     id_instr_q;
  logic [3:0]      mul_cnt_q;
  logic            hlt_seen_q;
  logic            wb_valid_q;
  logic [4:0]      wb_addr_q;
  logic [XLEN-1:0] wb_data_q;
  logic            wb_hlt_q;
  logic            halted_q;

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd, sa;
  logic [15:0]     imm;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] imm_sx;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] res_d;
  logic [4:0]      dest_d;
  logic            wr_en;
  logic            is_mul, is_hlt, id_done, accept, wb_we;

  assign opcode = id_instr_q[31:26];
  assign rs     = id_instr_q[25:21];
  assign rt     = id_instr_q[20:16];
  assign rd     = id_instr_q[15:11];
  assign sa     = id_instr_q[10:6];
  assign imm    = id_instr_q[15:0];
  assign imm_sx = XLEN'($signed(imm));

  // Shift amount only keeps the bits that index a single datapath word.
  generate
    if (SHW > 5) begin : g_shamt_wide
      assign shamt = {{(SHW-5){1'b0}}, sa};
    end else begin : g_shamt_narrow
      assign shamt = sa[SHW-1:0];
    end
  endgenerate

  assign is_mul   = (opcode == OP_MUL);
  assign is_hlt   = (opcode == OP_HLT);
  assign id_done  = id_valid_q && (!is_mul || mul_cnt_q <= 4'd1);
  assign in_ready = !hlt_seen_q && (!id_valid_q || id_done);
  assign accept   = in_valid && in_ready;

  // The WB value is one edge ahead of the bank, so it wins over the bank read.
  always_comb begin
    op_a = (rs == 5'd0) ? '0 : regs_q[rs];
    op_b = (rt == 5'd0) ? '0 : regs_q[rt];
    if (wb_valid_q && wb_addr_q == rs && rs != 5'd0) op_a = wb_data_q;
    if (wb_valid_q && wb_addr_q == rt && rt != 5'd0) op_b = wb_data_q;
  end

  always_comb begin
    res_d  = '0;
    dest_d = rd;
    wr_en  = 1'b1;
    case (opcode)
      OP_ADD:  res_d = op_a + op_b;
      OP_SUB:  res_d = op_a - op_b;
      OP_AND:  res_d = op_a & op_b;
      OP_OR:   res_d = op_a | op_b;
      OP_XOR:  res_d = op_a ^ op_b;
      OP_NOR:  res_d = ~(op_a | op_b);
      OP_SLT:  res_d = XLEN'($signed(op_a) < $signed(op_b));
      OP_MUL:  res_d = op_a * op_b;
      OP_ADDI: begin
        res_d  = op_a + imm_sx;
        dest_d = rt;
      end
      OP_SLL:  res_d = op_a << shamt;
      OP_SRL:  res_d = op_a >> shamt;
      OP_SRA:  res_d = $unsigned($signed(op_a) >>> shamt);
      default: wr_en = 1'b0;
    endcase
  end

  assign wb_we = id_done && wr_en && (dest_d != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      mul_cnt_q  <= '0;
      hlt_seen_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_hlt_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      if (accept) begin
        id_valid_q <= 1'b1;
        id_instr_q <= in_instr;
        mul_cnt_q  <= (in_instr[31:26] == OP_MUL) ? MUL_INIT : 4'd0;
        if (in_instr[31:26] == OP_HLT) hlt_seen_q <= 1'b1;
      end else if (id_done) begin
        id_valid_q <= 1'b0;
      end else if (id_valid_q && is_mul) begin
        mul_cnt_q <= mul_cnt_q - 4'd1;
      end
      wb_valid_q <= wb_we;
      if (wb_we) begin
        wb_addr_q <= dest_d;
        wb_data_q <= res_d;
      end
      wb_hlt_q <= id_done && is_hlt;
      if (wb_hlt_q) halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_valid_q) begin
      regs_q[wb_addr_q] <= wb_data_q;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign halted    = halted_q;
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs_q[dbg_raddr];
endmodule

// File: tb/tb_mips_alu_pipe.sv
// Directed bench for mips_alu_pipe: a 32-bit/3-stage-MUL instance and a 16-bit/1-stage-MUL instance.
module tb_mips_alu_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        halted;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  logic        in_valid16;
  logic        in_ready16;
  logic [31:0] in_instr16;
  logic        wb_valid16;
  logic [4:0]  wb_addr16;
  logic [15:0] wb_data16;
  logic        halted16;
  logic [4:0]  dbg_raddr16;
  logic [15:0] dbg_rdata16;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] ADD = 6'b000000, SLT = 6'b000100, MUL = 6'b000101, ADDI = 6'b001010;
  localparam logic [5:0] SRL = 6'b100111, SRA = 6'b101001, HLT = 6'b111111;

  always #5 clk = ~clk;

  mips_alu_pipe #(.XLEN(32), .MUL_STAGES(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .halted(halted),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  mips_alu_pipe #(.XLEN(16), .MUL_STAGES(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .in_instr(in_instr16),
    .wb_valid(wb_valid16), .wb_addr(wb_addr16), .wb_data(wb_data16), .halted(halted16),
    .dbg_raddr(dbg_raddr16), .dbg_rdata(dbg_rdata16)
  );

  function automatic logic [31:0] r_op(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                       logic [4:0] rd, logic [4:0] sa);
    return {op, rs, rt, rd, sa, 6'd0};
  endfunction

  function automatic logic [31:0] i_op(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_instr = '0; dbg_raddr = '0;
    in_valid16 = 1'b0; in_instr16 = '0; dbg_raddr16 = '0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (wb_valid !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0) begin
      errors++; $display("FAIL reset_wb got v=%b a=%0d d=%h want 0 0 0", wb_valid, wb_addr, wb_data); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    dbg_raddr = 5'd5; #1;
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_r5 got %h want 0", dbg_rdata); end
    step();
    $display("test_reset done");
  endtask

  task automatic test_forward();
    in_valid = 1'b1; in_instr = i_op(ADDI, 5'd0, 5'd1, 16'd5);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready0 got %b want 1", in_ready); end
    step();
    in_instr = r_op(ADD, 5'd1, 5'd1, 5'd2, 5'd0);
    checks++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL fwd_ready1 got ready=%b wb_valid=%b want 1 0", in_ready, wb_valid); end
    step();
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd1 || wb_data !== 32'd5 || in_ready !== 1'b1) begin
      errors++; $display("FAIL fwd_wb_r1 got v=%b a=%0d d=%h rdy=%b want 1 1 5 1", wb_valid, wb_addr, wb_data, in_ready); end
    in_valid = 1'b0;
    step();
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd2 || wb_data !== 32'd10) begin
      errors++; $display("FAIL fwd_wb_r2 got v=%b a=%0d d=%h want 1 2 a", wb_valid, wb_addr, wb_data); end
    step();
    dbg_raddr = 5'd2; #1;
    checks++; if (dbg_rdata !== 32'd10 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL fwd_bank_r2 got d=%h v=%b want a 0", dbg_rdata, wb_valid); end
    $display("test_forward done");
  endtask

  task automatic test_shift_slt();
    logic [31:0] prog [4];
    logic [4:0]  ea [4];
    logic [31:0] ed [4];
    prog = '{i_op(ADDI, 5'd0, 5'd3, 16'hFFFF), r_op(SRA, 5'd3, 5'd0, 5'd4, 5'd4),
             r_op(SLT, 5'd3, 5'd0, 5'd5, 5'd0), r_op(SRL, 5'd3, 5'd0, 5'd6, 5'd28)};
    ea = '{5'd3, 5'd4, 5'd5, 5'd6};
    ed = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hF};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin in_valid = 1'b1; in_instr = prog[i]; end
      else in_valid = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL shift_ready%0d got %b want 1", i, in_ready); end
      step();
      if (i >= 1) begin
        checks++; if (wb_valid !== 1'b1 || wb_addr !== ea[i-1] || wb_data !== ed[i-1]) begin
          errors++; $display("FAIL shift_wb%0d got v=%b a=%0d d=%h want 1 %0d %h", i-1, wb_valid, wb_addr, wb_data, ea[i-1], ed[i-1]); end
      end
    end
    $display("test_shift_slt done");
  endtask

  task automatic test_mul_interlock();
    int lows = 0;
    bit acc = 1'b0;
    in_valid = 1'b1; in_instr = i_op(ADDI, 5'd0, 5'd1, 16'd7); step();
    in_instr = i_op(ADDI, 5'd0, 5'd2, 16'd6); step();
    in_instr = r_op(MUL, 5'd1, 5'd2, 5'd6, 5'd0); step();
    in_instr = r_op(ADD, 5'd6, 5'd0, 5'd7, 5'd0);
    for (int k = 0; k < 20 && !acc; k++) begin
      if (in_ready === 1'b1) acc = 1'b1;
      else lows++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (!acc || lows != 2) begin
      errors++; $display("FAIL mul_stall got accepted=%b low_cycles=%0d want 1 2", acc, lows); end
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd6 || wb_data !== 32'd42) begin
      errors++; $display("FAIL mul_wb_r6 got v=%b a=%0d d=%h want 1 6 2a", wb_valid, wb_addr, wb_data); end
    step();
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'd42) begin
      errors++; $display("FAIL mul_wb_r7 got v=%b a=%0d d=%h want 1 7 2a", wb_valid, wb_addr, wb_data); end
    step();
    $display("test_mul_interlock done");
  endtask

  task automatic test_r0();
    bit seen = 1'b0;
    in_valid = 1'b1; in_instr = i_op(ADDI, 5'd0, 5'd0, 16'd9);
    step();
    in_valid = 1'b0;
    repeat (3) begin
      if (wb_valid !== 1'b0) seen = 1'b1;
      step();
    end
    checks++; if (seen) begin errors++; $display("FAIL r0_wb got wb_valid pulse want none"); end
    dbg_raddr = 5'd0; #1;
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL r0_read got %h want 0", dbg_rdata); end
    $display("test_r0 done");
  endtask

  task automatic test_halt();
    bit bad = 1'b0;
    dbg_raddr = 5'd1; #1;
    checks++; if (dbg_rdata !== 32'd7) begin errors++; $display("FAIL halt_pre_r1 got %h want 7", dbg_rdata); end
    in_valid = 1'b1; in_instr = r_op(HLT, 5'd0, 5'd0, 5'd0, 5'd0);
    step();
    in_instr = r_op(ADD, 5'd1, 5'd1, 5'd1, 5'd0);
    checks++; if (in_ready !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_e0 got ready=%b halted=%b want 0 0", in_ready, halted); end
    step();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_e1 got %b want 0", halted); end
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_e2 got %b want 1", halted); end
    repeat (20) begin
      if (halted !== 1'b1 || in_ready !== 1'b0 || wb_valid !== 1'b0) bad = 1'b1;
      step();
    end
    checks++; if (bad) begin errors++; $display("FAIL halt_hold got halted/ready/wb drift want 1/0/0"); end
    checks++; if (dbg_rdata !== 32'd7) begin errors++; $display("FAIL halt_r1 got %h want 7", dbg_rdata); end
    in_valid = 1'b0;
    $display("test_halt done");
  endtask

  task automatic test_reset_mid_mul();
    bit seen = 1'b0;
    bit nonzero = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    in_valid = 1'b1; in_instr = i_op(ADDI, 5'd0, 5'd1, 16'd3); step();
    in_instr = r_op(MUL, 5'd1, 5'd1, 5'd6, 5'd0); step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmul_async got wb_valid=%b ready=%b want 0 1", wb_valid, in_ready); end
    step();
    rst_n = 1'b1;
    repeat (4) begin
      if (wb_valid !== 1'b0) seen = 1'b1;
      step();
    end
    checks++; if (seen) begin errors++; $display("FAIL rstmul_wb got wb_valid pulse want none"); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmul_ready got %b want 1", in_ready); end
    for (int r = 0; r < 32; r++) begin
      dbg_raddr = 5'(r); #1;
      if (dbg_rdata !== 32'd0) nonzero = 1'b1;
    end
    checks++; if (nonzero) begin errors++; $display("FAIL rstmul_bank got nonzero register want all 0"); end
    $display("test_reset_mid_mul done");
  endtask

  task automatic test_xlen16();
    logic [31:0] prog [6];
    logic [4:0]  ea [6];
    logic [15:0] ed [6];
    prog = '{i_op(ADDI, 5'd0, 5'd1, 16'd5), r_op(ADD, 5'd1, 5'd1, 5'd2, 5'd0),
             i_op(ADDI, 5'd0, 5'd3, 16'hFFFF), r_op(SRL, 5'd3, 5'd0, 5'd4, 5'd20),
             r_op(MUL, 5'd3, 5'd3, 5'd5, 5'd0), r_op(ADD, 5'd5, 5'd2, 5'd6, 5'd0)};
    ea = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    ed = '{16'd5, 16'd10, 16'hFFFF, 16'h0FFF, 16'h0001, 16'h000B};
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin in_valid16 = 1'b1; in_instr16 = prog[i]; end
      else in_valid16 = 1'b0;
      checks++; if (in_ready16 !== 1'b1) begin errors++; $display("FAIL x16_ready%0d got %b want 1", i, in_ready16); end
      step();
      if (i >= 1) begin
        checks++; if (wb_valid16 !== 1'b1 || wb_addr16 !== ea[i-1] || wb_data16 !== ed[i-1]) begin
          errors++; $display("FAIL x16_wb%0d got v=%b a=%0d d=%h want 1 %0d %h", i-1, wb_valid16, wb_addr16, wb_data16, ea[i-1], ed[i-1]); end
      end
    end
    step();
    dbg_raddr16 = 5'd2; #1;
    checks++; if (dbg_rdata16 !== 16'd10) begin errors++; $display("FAIL x16_r2 got %h want a", dbg_rdata16); end
    $display("test_xlen16 done");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_shift_slt();
    test_mul_interlock();
    test_r0();
    test_halt();
    test_reset_mid_mul();
    test_xlen16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end
endmodule
